// File: rtl/mac_dot_accumulator.sv
// Sums LEN consecutive MAC products into one dot product behind valid/ready handshakes.
// Optional synchronous clear port enabled by defining MAC_ACC_CLEAR_EN.
module mac_dot_accumulator #(
  parameter int SIZE  = 3,
  parameter int LEN   = 8,
  parameter int ACC_W = 2*SIZE + $clog2(LEN+1)
) (
  input  logic                       clk,
  input  logic                       reset,
`ifdef MAC_ACC_CLEAR_EN
  input  logic                       clear,
`endif
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*SIZE-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_sum,
  output logic [$clog2(LEN+1)-1:0]   beat_cnt
);

  localparam int CNT_W = $clog2(LEN+1);

  if (LEN < 1) begin : g_len_check
    $error("mac_dot_accumulator: LEN must be >= 1");
  end

  typedef enum logic {ST_ACCUM, ST_HOLD} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               clr;
  logic [ACC_W-1:0]   acc_plus;

`ifdef MAC_ACC_CLEAR_EN
  assign clr = clear;
`else
  assign clr = 1'b0;
`endif

  assign acc_plus  = acc_q + ACC_W'(in_data);
  assign in_ready  = (state_q == ST_ACCUM) && !clr;
  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign beat_cnt  = cnt_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (clr) begin
      // clear outranks both a beat and an output handshake; out_sum is kept
      state_d = ST_ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (in_valid) begin
            if (cnt_q == CNT_W'(LEN-1)) begin
              sum_d   = acc_plus;
              valid_d = 1'b1;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = ST_HOLD;
            end else begin
              acc_d = acc_plus;
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            valid_d = 1'b0;
            state_d = ST_ACCUM;
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_mac_dot_accumulator.sv
// Directed bench for mac_dot_accumulator: LEN=4 instance plus a LEN=1 instance.
module tb_mac_dot_accumulator;

  logic       clk;
  logic       reset;
  logic       in_valid, out_ready;
  logic       in_ready, out_valid;
  logic [5:0] in_data;
  logic [7:0] out_sum;
  logic [2:0] beat_cnt;

  logic       in_valid1, out_ready1, in_ready1, out_valid1;
  logic [5:0] in_data1;
  logic [6:0] out_sum1;
  logic [0:0] beat_cnt1;

`ifdef MAC_ACC_CLEAR_EN
  logic       clear;
`endif

  int total = 0;
  int bad   = 0;

  mac_dot_accumulator #(.SIZE(3), .LEN(4), .ACC_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef MAC_ACC_CLEAR_EN
    .clear     (clear),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .beat_cnt  (beat_cnt)
  );

  mac_dot_accumulator #(.SIZE(3), .LEN(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
`ifdef MAC_ACC_CLEAR_EN
    .clear     (1'b0),
`endif
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_data   (in_data1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_sum   (out_sum1),
    .beat_cnt  (beat_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", out_valid); end
    total++; if (out_sum !== 8'd0) begin bad++; $display("FAIL rst_sum got=%0d exp=0", out_sum); end
    total++; if (beat_cnt !== 3'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", beat_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", in_ready); end
    total++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin bad++; $display("FAIL rst_len1 valid=%0b ready=%0b exp=0/1", out_valid1, in_ready1); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 6'd49;
      step();
      exp_cnt = (i == 3) ? 3'd0 : 3'(i + 1);
      total++; if (beat_cnt !== exp_cnt) begin bad++; $display("FAIL b2b_cnt[%0d] got=%0d exp=%0d", i, beat_cnt, exp_cnt); end
    end
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1 || out_sum !== 8'd196) begin bad++; $display("FAIL b2b_result valid=%0b sum=%0d exp=1/196", out_valid, out_sum); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_low got=%0b exp=0", in_ready); end
    step();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_release valid=%0b ready=%0b exp=0/1", out_valid, in_ready); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 6'(i);
      step();
    end
    in_data = 6'd50;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 8'd10) begin
        bad++; $display("FAIL bp_hold[%0d] ready=%0b valid=%0b sum=%0d exp=0/1/10", c, in_ready, out_valid, out_sum);
      end
      if (c < 4) step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release valid=%0b ready=%0b exp=0/1", out_valid, in_ready); end
    total++; if (out_sum !== 8'd10 || beat_cnt !== 3'd0) begin bad++; $display("FAIL bp_after sum=%0d cnt=%0d exp=10/0", out_sum, beat_cnt); end
  endtask

  task automatic test_gaps();
    logic [5:0] vals [4];
    vals[0] = 6'd5; vals[1] = 6'd0; vals[2] = 6'd7; vals[3] = 6'd3;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b0; in_data = 6'd63;
      step();
      total++; if (beat_cnt !== 3'(i)) begin bad++; $display("FAIL gap_idle_cnt[%0d] got=%0d exp=%0d", i, beat_cnt, i); end
      in_valid = 1'b1; in_data = vals[i];
      step();
    end
    in_valid = 1'b0;
    #1;
    total++; if (beat_cnt !== 3'd0) begin bad++; $display("FAIL gap_cnt_wrap got=%0d exp=0", beat_cnt); end
    total++; if (out_valid !== 1'b1 || out_sum !== 8'd15) begin bad++; $display("FAIL gap_result valid=%0b sum=%0d exp=1/15", out_valid, out_sum); end
    step();
  endtask

  task automatic test_reset_midgroup();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 6'd9;
      step();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (beat_cnt !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst cnt=%0d valid=%0b exp=0/0", beat_cnt, out_valid); end
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 6'd1;
      step();
    end
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_sum !== 8'd4) begin bad++; $display("FAIL mid_rst_sum valid=%0b sum=%0d exp=1/4", out_valid, out_sum); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (out_valid !== 1'b0 || out_sum !== 8'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL hold_rst valid=%0b sum=%0d ready=%0b exp=0/0/1", out_valid, out_sum, in_ready); end
    out_ready = 1'b1;
  endtask

  task automatic test_len1();
    out_ready1 = 1'b1;
    in_valid1 = 1'b1; in_data1 = 6'd36;
    step();
    in_data1 = 6'd12;
    #1;
    total++; if (out_valid1 !== 1'b1 || out_sum1 !== 7'd36 || in_ready1 !== 1'b0) begin bad++; $display("FAIL len1_first valid=%0b sum=%0d ready=%0b exp=1/36/0", out_valid1, out_sum1, in_ready1); end
    step();
    total++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || out_sum1 !== 7'd36) begin bad++; $display("FAIL len1_gap valid=%0b ready=%0b sum=%0d exp=0/1/36", out_valid1, in_ready1, out_sum1); end
    step();
    in_valid1 = 1'b0;
    total++; if (out_valid1 !== 1'b1 || out_sum1 !== 7'd12 || beat_cnt1 !== 1'b0) begin bad++; $display("FAIL len1_second valid=%0b sum=%0d cnt=%0d exp=1/12/0", out_valid1, out_sum1, beat_cnt1); end
    step();
  endtask

`ifdef MAC_ACC_CLEAR_EN
  task automatic test_clear();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 6'd9;
      step();
    end
    in_data = 6'd9;
    clear = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL clr_ready got=%0b exp=0", in_ready); end
    step();
    clear = 1'b0;
    total++; if (beat_cnt !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL clr_drop cnt=%0d valid=%0b exp=0/0", beat_cnt, out_valid); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 6'd2;
      step();
    end
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_sum !== 8'd8) begin bad++; $display("FAIL clr_sum valid=%0b sum=%0d exp=1/8", out_valid, out_sum); end
    step();
  endtask
`endif

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
`ifdef MAC_ACC_CLEAR_EN
    clear = 1'b0;
`endif
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_gaps();
    test_reset_midgroup();
    test_len1();
`ifdef MAC_ACC_CLEAR_EN
    test_clear();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
